// File: rtl/mc_wr_unpack_pkg.sv
// rtl/mc_wr_unpack_pkg.sv - bus-width constants and beat helpers for the write unpacker
package mc_wr_unpack_pkg;

  localparam logic [1:0] MC_BW_8  = 2'b00;
  localparam logic [1:0] MC_BW_16 = 2'b01;
  localparam logic [1:0] MC_BW_32 = 2'b10;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } mc_beat_sel_t;

  // 2'b11 falls into the default arms everywhere, so it behaves as a 32-bit bus
  function automatic logic [2:0] mc_nbeats(input logic [1:0] bw);
    case (bw)
      MC_BW_8:  return 3'd4;
      MC_BW_16: return 3'd2;
      default:  return 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] mc_lane_data(input logic [31:0] word, input logic [1:0] bw,
                                               input logic [1:0] idx);
    logic [31:0] s;
    s = '0;
    case (bw)
      MC_BW_8: begin
        s = word >> {idx, 3'b000};
        return {24'h0, s[7:0]};
      end
      MC_BW_16: begin
        s = word >> {idx[0], 4'b0000};
        return {16'h0, s[15:0]};
      end
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] mc_lane_be(input logic [3:0] be, input logic [1:0] bw,
                                            input logic [1:0] idx);
    logic [3:0] s;
    s = '0;
    case (bw)
      MC_BW_8: begin
        s = be >> idx;
        return {3'b000, s[0]};
      end
      MC_BW_16: begin
        s = be >> {idx[0], 1'b0};
        return {2'b00, s[1:0]};
      end
      default: return be;
    endcase
  endfunction

  function automatic logic [3:0] mc_lane_par(input logic [31:0] d);
    return {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
  endfunction

  // Lowest presentable beat at or above start; with skip set, zero-enable beats are passed over
  function automatic mc_beat_sel_t mc_find_beat(input logic [3:0] be, input logic [1:0] bw,
                                                input logic [2:0] start, input logic skip);
    mc_beat_sel_t sel;
    sel = '0;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) >= start && 3'(i) < mc_nbeats(bw) &&
          (!skip || mc_lane_be(be, bw, 2'(i)) != 4'h0)) begin
        sel.found = 1'b1;
        sel.idx   = 2'(i);
      end
    end
    return sel;
  endfunction

  function automatic logic mc_has_beat(input logic [3:0] be, input logic [1:0] bw,
                                       input logic [2:0] start, input logic skip);
    mc_beat_sel_t sel;
    sel = mc_find_beat(be, bw, start, skip);
    return sel.found;
  endfunction

endpackage

// File: rtl/mc_wr_fifo.sv
// rtl/mc_wr_fifo.sv - DEPTH x W write-word FIFO with synchronous flush and occupancy count
module mc_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && (r_count != (AW+1)'(DEPTH));
  assign w_pop  = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Head entry comes straight off the storage flops so a pop can load the hold register on the same edge
  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/mc_wr_unpack.sv
// rtl/mc_wr_unpack.sv - splits buffered 32-bit write words into 8/16/32-bit memory-bus beats
module mc_wr_unpack
  import mc_wr_unpack_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit SKIP_NULL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [1:0]  bus_width,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [31:0] wd_data,
  input  logic [3:0]  wd_be,
  output logic        mc_beat_valid,
  input  logic        mc_beat_ack,
  output logic [31:0] mc_data_o,
  output logic [3:0]  mc_dp_o,
  output logic [3:0]  mc_be_o,
  output logic [1:0]  mc_beat_idx,
  output logic        mc_beat_last,
  output logic        empty
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BEAT = 1'b1;
  localparam int   CW      = $clog2(DEPTH) + 1;

  logic          r_state;
  logic [31:0]   r_word;
  logic [3:0]    r_be;
  logic [1:0]    r_bw;
  logic [1:0]    r_idx;
  logic          r_last;
  logic [31:0]   r_data_o;
  logic [3:0]    r_dp_o;
  logic [3:0]    r_be_o;

  logic [CW-1:0] w_count;
  logic [35:0]   w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_ack;
  mc_beat_sel_t  w_first;
  mc_beat_sel_t  w_adv;
  logic          w_n_state;
  logic [31:0]   w_n_word;
  logic [3:0]    w_n_be;
  logic [1:0]    w_n_bw;
  logic [1:0]    w_n_idx;
  logic          w_n_more;
  logic [31:0]   w_n_data;

  assign wd_ready = !rst && (w_count < CW'(DEPTH));
  assign w_push   = wd_valid && wd_ready && !clr;
  assign w_ack    = (r_state == ST_BEAT) && mc_beat_ack;
  assign w_pop    = !clr && (w_count != '0) && ((r_state == ST_IDLE) || (w_ack && r_last));

  mc_wr_fifo #(.DEPTH(DEPTH), .W(36)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({wd_be, wd_data}),
    .dout  (w_head),
    .count (w_count)
  );

  assign w_first = mc_find_beat(w_head[35:32], bus_width, 3'd0, SKIP_NULL);
  assign w_adv   = mc_find_beat(r_be, r_bw, {1'b0, r_idx} + 3'd1, SKIP_NULL);

  always_comb begin
    w_n_state = r_state;
    w_n_word  = r_word;
    w_n_be    = r_be;
    w_n_bw    = r_bw;
    w_n_idx   = r_idx;
    if (clr) begin
      w_n_state = ST_IDLE;
    end else if (w_pop) begin
      // A word with nothing to present is consumed here and the FSM stays idle
      w_n_word  = w_head[31:0];
      w_n_be    = w_head[35:32];
      w_n_bw    = bus_width;
      w_n_idx   = w_first.idx;
      w_n_state = w_first.found ? ST_BEAT : ST_IDLE;
    end else if (w_ack) begin
      if (r_last || !w_adv.found) w_n_state = ST_IDLE;
      else                        w_n_idx   = w_adv.idx;
    end
  end

  assign w_n_more = mc_has_beat(w_n_be, w_n_bw, {1'b0, w_n_idx} + 3'd1, SKIP_NULL);
  assign w_n_data = mc_lane_data(w_n_word, w_n_bw, w_n_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_word   <= '0;
      r_be     <= '0;
      r_bw     <= MC_BW_8;
      r_idx    <= '0;
      r_last   <= 1'b0;
      r_data_o <= '0;
      r_dp_o   <= '0;
      r_be_o   <= '0;
    end else begin
      r_state <= w_n_state;
      r_word  <= w_n_word;
      r_be    <= w_n_be;
      r_bw    <= w_n_bw;
      r_idx   <= w_n_idx;
      r_last  <= (w_n_state == ST_BEAT) && !w_n_more;
      if (w_n_state == ST_BEAT) begin
        r_data_o <= w_n_data;
        r_dp_o   <= mc_lane_par(w_n_data);
        r_be_o   <= mc_lane_be(w_n_be, w_n_bw, w_n_idx);
      end else begin
        r_data_o <= '0;
        r_dp_o   <= '0;
        r_be_o   <= '0;
      end
    end
  end

  assign mc_beat_valid = (r_state == ST_BEAT);
  assign mc_data_o     = r_data_o;
  assign mc_dp_o       = r_dp_o;
  assign mc_be_o       = r_be_o;
  assign mc_beat_idx   = r_idx;
  assign mc_beat_last  = r_last;
  assign empty         = (w_count == '0) && (r_state == ST_IDLE);

endmodule
